// File: rtl/tx_pkg.sv
// tx_pkg: definitions shared by the link transmitter (tx) and receiver (rx).
//   - tx_state_e        : transmitter FSM state encoding
//   - DEFAULT_SIZE      : default flit width in bits (MSB is the head flag)
//   - DEFAULT_BUFF_BITS : default packet buffer address width
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_FETCH    = 2'b01,
    ST_WAIT_ACK = 2'b10,
    ST_DONE     = 2'b11
  } tx_state_e;

  localparam int DEFAULT_SIZE      = 8;
  localparam int DEFAULT_BUFF_BITS = 3;

endpackage

// File: rtl/tx_toggle_detect.sv
// toggle_detect: registered XOR edge detector for two-phase handshake lines.
// Every change of level on sig is reported as a one-cycle event.
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-low reset; clears the history register
//   sig   in  two-phase line to watch (already synchronous to clk)
//   evt   out high while sig differs from its value at the previous edge
module toggle_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic evt
);

  logic sig_old;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_old <= 1'b0;
    end else begin
      sig_old <= sig;
    end
  end

  assign evt = sig ^ sig_old;

endmodule

// File: rtl/tx.sv
// tx: channel transmitter. On a switch request it reads one packet of
// 2**BUFF_BITS flits from the source buffer and sends them one by one over a
// two-phase req/ack flit channel, then reports completion to the switch with
// a four-phase sw_req/sw_ack handshake.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset
//   sw_req   in  switch request (level)
//   sw_ack   out packet fully acknowledged by the far end
//   buf_addr out source buffer read address (current flit index)
//   buf_data in  source buffer read data, combinational from buf_addr
//   ch_req   out channel request, toggles once per flit
//   ch_flit  out channel data, stable between ch_req toggles
//   ch_ack   in  channel acknowledge, each toggle is one acknowledge
module tx
  import tx_pkg::*;
#(
  parameter int ID        = 0,
  parameter     MOD_NAME  = "TX",
  parameter int SIZE      = DEFAULT_SIZE,
  parameter int BUFF_BITS = DEFAULT_BUFF_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sw_req,
  output logic                 sw_ack,
  output logic [BUFF_BITS-1:0] buf_addr,
  input  logic [SIZE-1:0]      buf_data,
  output logic                 ch_req,
  output logic [SIZE-1:0]      ch_flit,
  input  logic                 ch_ack
);

  // ID and MOD_NAME only tag the instance; nothing is generated from them.
  if (ID < 0 || $bits(MOD_NAME) == 0) begin : g_untagged_instance
  end

  tx_state_e            state, state_next;
  logic [BUFF_BITS-1:0] flit_counter, flit_counter_next;
  logic                 ch_req_next;
  logic [SIZE-1:0]      ch_flit_next;
  logic                 sw_ack_next;
  logic                 ack_evt;
  logic                 last_flit;

  // The ack history register updates in every state, so a toggle that lands
  // outside ST_WAIT_ACK is absorbed and never seen later as a fresh ack.
  toggle_detect u_ack_detect (
    .clk   (clk),
    .reset (reset),
    .sig   (ch_ack),
    .evt   (ack_evt)
  );

  // The packet length is a power of two, so the last index is all ones.
  assign last_flit = &flit_counter;
  assign buf_addr  = flit_counter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      flit_counter <= '0;
      ch_req       <= 1'b0;
      ch_flit      <= '0;
      sw_ack       <= 1'b0;
    end else begin
      state        <= state_next;
      flit_counter <= flit_counter_next;
      ch_req       <= ch_req_next;
      ch_flit      <= ch_flit_next;
      sw_ack       <= sw_ack_next;
    end
  end

  always_comb begin
    state_next        = state;
    flit_counter_next = flit_counter;
    ch_req_next       = ch_req;
    ch_flit_next      = ch_flit;
    sw_ack_next       = sw_ack;

    unique case (state)
      ST_IDLE: begin
        if (sw_req) begin
          flit_counter_next = '0;
          state_next        = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // buf_data already reflects flit_counter, so latch and announce it.
        ch_flit_next = buf_data;
        ch_req_next  = ~ch_req;
        state_next   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (ack_evt) begin
          if (last_flit) begin
            sw_ack_next = 1'b1;
            state_next  = ST_DONE;
          end else begin
            flit_counter_next = flit_counter + 1'b1;
            state_next        = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (!sw_req) begin
          sw_ack_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx.sv
// tb_tx: directed bench for tx with a scoreboard of expected flits and a
// loopback far-end that acknowledges each flit three cycles after its toggle.
module tb_tx;

  localparam int SIZE      = 8;
  localparam int BUFF_BITS = 3;
  localparam int NFLIT     = 2 ** BUFF_BITS;

  logic                 clk;
  logic                 reset;
  logic                 sw_req;
  logic                 sw_ack;
  logic [BUFF_BITS-1:0] buf_addr;
  logic [SIZE-1:0]      buf_data;
  logic                 ch_req;
  logic [SIZE-1:0]      ch_flit;
  logic                 ch_ack;

  logic [SIZE-1:0] buf_mem [NFLIT];
  assign buf_data = buf_mem[buf_addr];

  tx #(.ID(0), .MOD_NAME("TX"), .SIZE(SIZE), .BUFF_BITS(BUFF_BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_req   (sw_req),
    .sw_ack   (sw_ack),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .ch_req   (ch_req),
    .ch_flit  (ch_flit),
    .ch_ack   (ch_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [SIZE-1:0] exp_q [$];
  int  toggle_count = 0;
  int  auto_acks    = 0;
  int  pkt_start    = 0;
  int  stall_idx    = -1;
  int  ack_pending  = 0;
  logic prev_req    = 1'b0;
  logic req_phase   = 1'b0;   // expected ch_req level, kept by the bench

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Channel monitor and loopback far end, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      prev_req    = ch_req;
      ack_pending = 0;
    end else begin
      if (ack_pending > 0) begin
        ack_pending = ack_pending - 1;
        if (ack_pending == 0) begin
          ch_ack    = ~ch_ack;
          auto_acks = auto_acks + 1;
        end
      end
      if (ch_req !== prev_req) begin
        prev_req     = ch_req;
        toggle_count = toggle_count + 1;
        req_phase    = ~req_phase;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_toggle: got flit 0x%0h expected no toggle", ch_flit);
        end else begin
          logic [SIZE-1:0] e;
          e = exp_q.pop_front();
          assert (ch_flit === e) else begin
            errors++;
            $error("FAIL flit: got 0x%0h expected 0x%0h", ch_flit, e);
          end
          $display("flit %0d sent: 0x%0h", toggle_count - pkt_start - 1, ch_flit);
        end
        if (toggle_count - pkt_start - 1 != stall_idx) ack_pending = 3;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_buf(input int seed);
    for (int i = 0; i < NFLIT; i++) begin
      if (seed == 0) buf_mem[i] = (i == 0) ? 8'h80 : 8'(i);
      else           buf_mem[i] = (i == 0) ? (8'h80 | 8'($urandom_range(0, 127)))
                                           : 8'($urandom_range(0, 127));
    end
  endtask

  task automatic push_packet();
    for (int i = 0; i < NFLIT; i++) exp_q.push_back(buf_mem[i]);
  endtask

  // Wait for sw_ack with a cycle budget; returns 1 when seen.
  task automatic wait_sw_ack(input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (sw_ack) seen = 1'b1;
    end
    if (!seen) check({tag, "_sw_ack_timeout"}, 32'(sw_ack), 32'd1);
  endtask

  // Normal packet: returns with sw_req low and sw_ack observed falling.
  task automatic run_packet(input string tag, input bit back_to_back);
    bit seen;
    int acks0;
    pkt_start = toggle_count;
    acks0     = auto_acks;
    push_packet();
    sw_req = 1'b1;
    wait_sw_ack(tag, seen);
    check({tag, "_toggles"}, 32'(toggle_count - pkt_start), 32'(NFLIT));
    check({tag, "_acks_before_done"}, 32'(auto_acks - acks0), 32'(NFLIT));
    check({tag, "_req_phase"}, 32'(ch_req), 32'(req_phase));
    $display("%s: packet complete, sw_ack high", tag);
    cycles(1);
    check({tag, "_sw_ack_held"}, 32'(sw_ack), 32'd1);
    sw_req = 1'b0;
    cycles(1);
    check({tag, "_sw_ack_fall"}, 32'(sw_ack), 32'd0);
    if (back_to_back) sw_req = 1'b1;
  endtask

  initial begin
    bit seen;
    int t0;
    logic [SIZE-1:0] held_flit;
    logic            held_req;
    bit              stable;

    reset  = 1'b0;
    sw_req = 1'b0;
    ch_ack = 1'b0;
    load_buf(0);
    cycles(2);
    check("reset_sw_ack",  32'(sw_ack), 32'd0);
    check("reset_ch_req",  32'(ch_req), 32'd0);
    check("reset_ch_flit", 32'(ch_flit), 32'd0);
    check("reset_addr",    32'(buf_addr), 32'd0);
    reset = 1'b1;
    cycles(3);
    check("idle_no_toggle", 32'(toggle_count), 32'd0);

    // Single packet 0x80,0x01..0x07, then an immediate second packet.
    run_packet("pkt1", 1'b1);
    load_buf(1);
    run_packet("pkt2", 1'b0);
    check("b2b_total_toggles", 32'(toggle_count), 32'(2 * NFLIT));

    // Spurious acks in ST_DONE and ST_IDLE.
    load_buf(1);
    push_packet();
    pkt_start = toggle_count;
    sw_req = 1'b1;
    wait_sw_ack("spur", seen);
    ch_ack = ~ch_ack;          // extra toggle while in ST_DONE
    cycles(2);
    sw_req = 1'b0;
    cycles(3);
    ch_ack = ~ch_ack;          // extra toggle while in ST_IDLE
    t0 = toggle_count;
    cycles(6);
    check("spur_no_toggle", 32'(toggle_count - t0), 32'd0);
    check("spur_sw_ack_low", 32'(sw_ack), 32'd0);
    load_buf(1);
    run_packet("spur_next", 1'b0);

    // Stall on flit 3 for 50 cycles.
    load_buf(1);
    push_packet();
    pkt_start = toggle_count;
    stall_idx = 3;
    sw_req = 1'b1;
    for (int i = 0; i < 200 && toggle_count - pkt_start < 4; i++) cycles(1);
    check("stall_reached", 32'(toggle_count - pkt_start), 32'd4);
    held_flit = ch_flit;
    held_req  = ch_req;
    stable    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (ch_flit !== held_flit || ch_req !== held_req || buf_addr !== 3'd3) stable = 1'b0;
    end
    check("stall_stable", 32'(stable), 32'd1);
    check("stall_addr", 32'(buf_addr), 32'd3);
    check("stall_flit", 32'(ch_flit), 32'(buf_mem[3]));
    stall_idx = -1;
    ch_ack = ~ch_ack;
    wait_sw_ack("stall", seen);
    check("stall_toggles", 32'(toggle_count - pkt_start), 32'(NFLIT));
    sw_req = 1'b0;
    cycles(2);

    // Reset while waiting on flit 5.
    load_buf(1);
    push_packet();
    pkt_start = toggle_count;
    stall_idx = 5;
    sw_req = 1'b1;
    for (int i = 0; i < 200 && toggle_count - pkt_start < 6; i++) cycles(1);
    check("rst_reached", 32'(toggle_count - pkt_start), 32'd6);
    cycles(2);
    #2;
    reset  = 1'b0;
    ch_ack = 1'b0;
    sw_req = 1'b0;
    #1;
    check("rst_async_ch_req",  32'(ch_req), 32'd0);
    check("rst_async_ch_flit", 32'(ch_flit), 32'd0);
    check("rst_async_addr",    32'(buf_addr), 32'd0);
    check("rst_async_sw_ack",  32'(sw_ack), 32'd0);
    exp_q.delete();
    req_phase = 1'b0;
    stall_idx = -1;
    cycles(2);
    reset = 1'b1;
    t0 = toggle_count;
    cycles(20);
    check("rst_no_toggle", 32'(toggle_count - t0), 32'd0);
    load_buf(0);
    run_packet("post_rst", 1'b0);

    // Early sw_req drop after flit 2.
    load_buf(1);
    push_packet();
    pkt_start = toggle_count;
    sw_req = 1'b1;
    for (int i = 0; i < 200 && toggle_count - pkt_start < 3; i++) cycles(1);
    sw_req = 1'b0;
    wait_sw_ack("early", seen);
    check("early_toggles", 32'(toggle_count - pkt_start), 32'(NFLIT));
    cycles(1);
    check("early_sw_ack_one_cycle", 32'(sw_ack), 32'd0);
    cycles(5);
    check("early_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
